dmem_access_ctrl: RTL and testbench

Sequences every load/store between the core's memory stage and the single-port data memory. Generates the byte mask and the lane-rotated write data. Splits misaligned accesses into two word-aligned beats, then reassembles and sign/zero-extends load data. Sits between the memory-stage pipeline register and the dmem interface, with one access outstanding at a time.

---
 rtl/dmem_access_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the memory stage and a single-port data memory.
// Splits misaligned accesses into two word beats and reassembles/extends load data.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter bit          ALLOW_SPLIT = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wen,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_rsp_valid,
    output logic              o_rsp_err,
    output logic [31:0]       o_rdata,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [3:0]        o_mem_mask,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;

    state_t              state;
    logic                wen;
    logic [2:0]          f3;
    logic [1:0]          off;
    logic [3:0]          mask1;
    logic                split;
    logic [31:0]         asm_data;

    logic [3:0]          size_lanes;
    logic [7:0]          req_lanes;
    logic                req_illegal;
    logic                req_err;
    logic [31:0]         merged;
    logic [31:0]         load_result;

    function automatic logic [31:0] rotl(input logic [31:0] d, input logic [1:0] o);
        case (o)
            2'd0:    rotl = d;
            2'd1:    rotl = {d[23:0], d[31:24]};
            2'd2:    rotl = {d[15:0], d[31:16]};
            default: rotl = {d[7:0], d[31:8]};
        endcase
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] d, input logic [1:0] o);
        case (o)
            2'd0:    rotr = d;
            2'd1:    rotr = {d[7:0], d[31:8]};
            2'd2:    rotr = {d[15:0], d[31:16]};
            default: rotr = {d[23:0], d[31:24]};
        endcase
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        lane_bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f);
        case (f[1:0])
            2'b00:   extend = f[2] ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   extend = f[2] ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    assign o_req_ready = (state == IDLE);

    // Request decode: byte lanes over two adjacent words, and the error condition
    always_comb begin
        case (i_funct3[1:0])
            2'b00:   size_lanes = 4'b0001;
            2'b01:   size_lanes = 4'b0011;
            default: size_lanes = 4'b1111;
        endcase
        req_lanes   = {4'b0000, size_lanes} << i_addr[1:0];
        req_illegal = (i_funct3[1:0] == 2'b11) || (i_req_wen && i_funct3[2]);
        req_err     = req_illegal || (!ALLOW_SPLIT && (req_lanes[7:4] != 4'b0000));
    end

    // The current beat's mask is still held in o_mem_mask while waiting for read data
    always_comb begin
        merged      = (asm_data & ~lane_bits(o_mem_mask)) | (i_mem_rdata & lane_bits(o_mem_mask));
        load_result = extend(rotr(merged, off), f3);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            wen         <= 1'b0;
            f3          <= 3'b000;
            off         <= 2'b00;
            mask1       <= 4'b0000;
            split       <= 1'b0;
            asm_data    <= 32'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rdata     <= 32'b0;
            o_mem_valid <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wen   <= 1'b0;
            o_mem_mask  <= 4'b0000;
            o_mem_wdata <= 32'b0;
        end else begin
            o_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        wen      <= i_req_wen;
                        f3       <= i_funct3;
                        off      <= i_addr[1:0];
                        mask1    <= req_lanes[7:4];
                        split    <= (req_lanes[7:4] != 4'b0000);
                        asm_data <= 32'b0;
                        if (req_err) begin
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                            o_rdata     <= 32'b0;
                        end else begin
                            state       <= BEAT0;
                            o_mem_valid <= 1'b1;
                            o_mem_wen   <= i_req_wen;
                            o_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                            o_mem_mask  <= req_lanes[3:0];
                            o_mem_wdata <= rotl(i_wdata, i_addr[1:0]);
                        end
                    end
                end
                BEAT0: begin
                    if (i_mem_ready) begin
                        if (wen && split) begin
                            state      <= BEAT1;
                            o_mem_addr <= o_mem_addr + ADDR_W'(4);
                            o_mem_mask <= mask1;
                        end else begin
                            o_mem_valid <= 1'b0;
                            if (wen) begin
                                state       <= RESP;
                                o_rsp_valid <= 1'b1;
                                o_rdata     <= 32'b0;
                            end else begin
                                state <= WAIT0;
                            end
                        end
                    end
                end
                WAIT0: begin
                    if (i_mem_rvalid) begin
                        if (split) begin
                            asm_data    <= merged;
                            state       <= BEAT1;
                            o_mem_valid <= 1'b1;
                            o_mem_addr  <= o_mem_addr + ADDR_W'(4);
                            o_mem_mask  <= mask1;
                        end else begin
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                            o_rdata     <= load_result;
                        end
                    end
                end
                BEAT1: begin
                    if (i_mem_ready) begin
                        o_mem_valid <= 1'b0;
                        if (wen) begin
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                            o_rdata     <= 32'b0;
                        end else begin
                            state <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    if (i_mem_rvalid) begin
                        state       <= RESP;
                        o_rsp_valid <= 1'b1;
                        o_rdata     <= load_result;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    o_rsp_err <= 1'b0;
                    o_rdata   <= 32'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: byte-level reference memory predicts beats and responses,
// a memory responder and a response monitor check the DUT independently of the stimulus.
module tb_dmem_access_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid, o_req_ready, i_req_wen;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic        o_rsp_valid, o_rsp_err;
    logic [31:0] o_rdata;
    logic        o_mem_valid, i_mem_ready, o_mem_wen;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    logic        req_valid2, ready2, rsp_valid2, rsp_err2, mem_valid2, mem_wen2;
    logic [31:0] rdata2, mem_addr2, mem_wdata2;
    logic [3:0]  mem_mask2;

    dmem_access_ctrl #(.ADDR_W(32), .ALLOW_SPLIT(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_err(o_rsp_err), .o_rdata(o_rdata),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
        .o_mem_wen(o_mem_wen), .o_mem_mask(o_mem_mask), .o_mem_wdata(o_mem_wdata),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    dmem_access_ctrl #(.ADDR_W(32), .ALLOW_SPLIT(1'b0)) dut_nosplit (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(req_valid2), .o_req_ready(ready2), .i_req_wen(i_req_wen),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_rsp_valid(rsp_valid2), .o_rsp_err(rsp_err2), .o_rdata(rdata2),
        .o_mem_valid(mem_valid2), .i_mem_ready(1'b1), .o_mem_addr(mem_addr2),
        .o_mem_wen(mem_wen2), .o_mem_mask(mem_mask2), .o_mem_wdata(mem_wdata2),
        .i_mem_rvalid(1'b0), .i_mem_rdata(32'h0)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          t0;
    } rsp_t;

    beat_t       beat_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] pmem [logic [31:0]];
    logic [7:0]  rmem [logic [31:0]];

    int errs = 0;
    int checks = 0;
    int ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
    int rv_delay = 1;     // 0 random 1..3
    bit rv_block = 1'b0;

    function automatic logic [31:0] init_word(input logic [31:0] w);
        return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] w);
        if (pmem.exists(w)) return pmem[w];
        return init_word(w);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (rmem.exists(a)) return rmem[a];
        w = init_word({a[31:2], 2'b00});
        return 8'(w >> (8 * int'(a[1:0])));
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] w, input logic [31:0] v);
        pmem[w] = v;
        for (int i = 0; i < 4; i++) rmem[w + 32'(i)] = 8'(v >> (8 * i));
    endtask

    // Predict beats and response from byte-addressed rules, then present the request
    task automatic issue(input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat);
        int          n;
        int          size;
        int          lane;
        logic [31:0] ba, value;
        beat_t       cur;
        rsp_t        r;
        n = 0;
        @(negedge i_clk);
        while (!o_req_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) begin
            chk("req_ready timeout", 32'(o_req_ready), 32'd1);
            return;
        end
        r.err   = (f3[1:0] == 2'b11) || (wen && f3[2]);
        r.rdata = 32'h0;
        r.lat   = lat;
        r.t0    = cyc;
        if (!r.err) begin
            size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
            value = 32'h0;
            cur   = '0;
            for (int i = 0; i < size; i++) begin
                ba   = addr + 32'(i);
                lane = int'(ba[1:0]);
                if (i == 0 || {ba[31:2], 2'b00} != cur.addr) begin
                    if (i != 0) beat_q.push_back(cur);
                    cur      = '0;
                    cur.addr = {ba[31:2], 2'b00};
                    cur.wen  = wen;
                end
                cur.mask[lane] = 1'b1;
                if (wen) begin
                    cur.wdata[8*lane +: 8] = wdata[8*i +: 8];
                    rmem[ba] = wdata[8*i +: 8];
                end else begin
                    value = value | (32'(ref_byte(ba)) << (8 * i));
                end
            end
            beat_q.push_back(cur);
            if (!wen) begin
                if (size == 1)      r.rdata = f3[2] ? value : {{24{value[7]}}, value[7:0]};
                else if (size == 2) r.rdata = f3[2] ? value : {{16{value[15]}}, value[15:0]};
                else                r.rdata = value;
            end
        end
        rsp_q.push_back(r);
        i_req_valid = 1'b1;
        i_req_wen   = wen;
        i_funct3    = f3;
        i_addr      = addr;
        i_wdata     = wdata;
        @(negedge i_clk);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || beat_q.size() != 0 || !o_req_ready) && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 500) chk("idle timeout", 32'(rsp_q.size() + beat_q.size()), 32'd0);
    endtask

    // Memory responder: checks each accepted beat and models the word memory
    int          rd_cnt = 0;
    bit          rd_pend = 1'b0;
    logic [31:0] rd_word;
    initial begin
        beat_t e;
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'h0;
        forever begin
            @(negedge i_clk);
            i_mem_rvalid = 1'b0;
            if (rd_pend && !rv_block) begin
                rd_cnt--;
                if (rd_cnt <= 0) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = rd_word;
                    rd_pend      = 1'b0;
                end
            end
            case (ready_mode)
                0:       i_mem_ready = ($urandom_range(0, 3) != 0);
                1:       i_mem_ready = 1'b1;
                default: i_mem_ready = 1'b0;
            endcase
            if (!i_rst && o_mem_valid && i_mem_ready) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected beat", 32'd0, 32'd1);
                end else begin
                    e = beat_q.pop_front();
                    chk("beat addr", o_mem_addr, e.addr);
                    chk("beat wen", 32'(o_mem_wen), 32'(e.wen));
                    chk("beat mask", 32'(o_mem_mask), 32'(e.mask));
                    if (e.wen) chk("beat wdata", o_mem_wdata & lane_bits(e.mask), e.wdata);
                end
                if (o_mem_wen) begin
                    pmem[o_mem_addr] = (phys_rd(o_mem_addr) & ~lane_bits(o_mem_mask)) |
                                       (o_mem_wdata & lane_bits(o_mem_mask));
                end else begin
                    rd_pend = 1'b1;
                    rd_cnt  = (rv_delay > 0) ? rv_delay : int'($urandom_range(1, 3));
                    rd_word = phys_rd(o_mem_addr);
                end
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected rsp", 32'd0, 32'd1);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp err", 32'(o_rsp_err), 32'(r.err));
                    chk("rsp rdata", o_rdata, r.rdata);
                    if (r.lat > 0) chk("rsp latency", 32'(cyc - r.t0), 32'(r.lat));
                end
            end
        end
    end

    initial begin
        logic [31:0] a0, d0;
        logic [3:0]  m0;
        logic [2:0]  f3;
        logic [31:0] addr;
        bit          wen;
        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        req_valid2  = 1'b0;
        i_req_wen   = 1'b0;
        i_funct3    = 3'b000;
        i_addr      = 32'h0;
        i_wdata     = 32'h0;
        @(negedge i_clk);
        chk("reset mem_valid", 32'(o_mem_valid), 32'd0);
        chk("reset rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("reset req_ready", 32'(o_req_ready), 32'd1);
        chk("reset mem_mask", 32'(o_mem_mask), 32'd0);
        chk("reset mem_wdata", o_mem_wdata, 32'd0);
        chk("reset rdata", o_rdata, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Directed cases with fixed latency
        preload(32'h100, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 3);
        issue(1'b1, 3'b000, 32'h203, 32'h000000A5, 2);
        wait_idle();
        preload(32'h0FC, 32'h80112233);
        preload(32'h100, 32'h44556677);
        issue(1'b0, 3'b001, 32'h0FF, 32'h0, 5);
        issue(1'b0, 3'b101, 32'h0FF, 32'h0, 5);
        issue(1'b0, 3'b000, 32'h0FF, 32'h0, 3);
        issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'h11223344, 3);
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 5);
        issue(1'b0, 3'b011, 32'h100, 32'h0, 1);
        issue(1'b1, 3'b100, 32'h100, 32'h0, 1);
        wait_idle();

        // Stalled beat stays stable, then reset abandons it
        ready_mode = 2;
        issue(1'b0, 3'b010, 32'h40, 32'h0, 0);
        a0 = o_mem_addr;
        m0 = o_mem_mask;
        d0 = o_mem_wdata;
        chk("stall valid", 32'(o_mem_valid), 32'd1);
        repeat (5) begin
            @(negedge i_clk);
            chk("stall valid", 32'(o_mem_valid), 32'd1);
            chk("stall addr", o_mem_addr, a0);
            chk("stall mask", 32'(o_mem_mask), 32'(m0));
            chk("stall wdata", o_mem_wdata, d0);
        end
        #2 i_rst = 1'b1;
        #1;
        chk("rst drops mem_valid", 32'(o_mem_valid), 32'd0);
        chk("rst req_ready", 32'(o_req_ready), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b0;
        beat_q.delete();
        rsp_q.delete();

        // Reset in WAIT0; the late read data must be ignored
        ready_mode = 1;
        rv_block   = 1'b1;
        issue(1'b0, 3'b010, 32'h44, 32'h0, 0);
        @(negedge i_clk);
        chk("wait0 mem_valid", 32'(o_mem_valid), 32'd0);
        #2 i_rst = 1'b1;
        #1;
        chk("rst wait0 mem_valid", 32'(o_mem_valid), 32'd0);
        chk("rst wait0 req_ready", 32'(o_req_ready), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b0;
        beat_q.delete();
        rsp_q.delete();
        rv_block = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            chk("stray rvalid rsp", 32'(o_rsp_valid), 32'd0);
            chk("stray rvalid ready", 32'(o_req_ready), 32'd1);
        end

        // Randomized traffic around a normal region and the address wrap point
        ready_mode = 0;
        rv_delay   = 0;
        repeat (150) begin
            wen  = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 1) != 0 ? 32'hFFFFFFF0 : 32'h00000100) + 32'($urandom_range(0, 15));
            issue(wen, f3, addr, $urandom, 0);
        end
        wait_idle();

        // Misaligned access without splitting is an error with no memory beat
        @(negedge i_clk);
        i_req_wen  = 1'b0;
        i_funct3   = 3'b010;
        i_addr     = 32'h101;
        req_valid2 = 1'b1;
        @(negedge i_clk);
        req_valid2 = 1'b0;
        chk("nosplit rsp_valid", 32'(rsp_valid2), 32'd1);
        chk("nosplit rsp_err", 32'(rsp_err2), 32'd1);
        chk("nosplit rdata", rdata2, 32'd0);
        chk("nosplit mem_valid", 32'(mem_valid2), 32'd0);
        @(negedge i_clk);
        chk("nosplit rsp_valid drop", 32'(rsp_valid2), 32'd0);
        chk("nosplit ready", 32'(ready2), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
